sample_pipe: RTL and testbench
==============================

Name: sample_pipe

Overview:
- Parametrised, pipelined successor of the single-bit `sample` logic cone.
- Evaluates the cone bitwise over WIDTH parallel lanes, then carries results through STAGES register stages under a valid/ready handshake.
- Includes a saturating event counter that tallies asserted `o` lanes on output transfers.
- Sits between the stimulus source and the result checker in the synthesis-demo datapath.

Parameters:
- WIDTH, 8, number of bit lanes per operand (1..64)
- STAGES, 2, pipeline register depth; equals latency in cycles (1..4)
- CNT_W, 16, width of the o-lane event counter (4..32)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operands valid
- in_ready  out  1  pipeline can accept input this cycle
- a, b, c, d, e, f  in  WIDTH each  operand lanes
- out_valid  out  1  o/p/q hold a valid result
- out_ready  in  1  consumer accepts the result
- o, p, q  out  WIDTH each  result lanes
- cnt_clr  in  1  synchronous clear of o_cnt
- o_cnt  out  CNT_W  saturating count of set o bits over accepted outputs
- o_cnt_sat  out  1  o_cnt has reached all-ones

Behaviour:
- Lane function, bitwise and identical in every lane, computed combinationally at the input:
  - g = a|d, h = a&c, i = ~c, j = d|e|f
  - k = g|h|i, l = h&i&j, m = i&j, n = l&m
  - o = b&h&k, p = ~g, q = ~n
- Only o, p and q are registered; intermediate terms are not stored.
- Pipeline structure:
  - Stage registers s[0..STAGES-1], each holding valid bit v[s] plus o/p/q data.
  - adv[STAGES-1] = out_ready | ~v[STAGES-1]
  - adv[s] = adv[s+1] | ~v[s]
  - in_ready = adv[0]. It is combinational from out_ready; no skid buffer.
  - When adv[s] is high, stage s loads from stage s-1 (stage 0 loads from the input). The loaded valid is in_valid & in_ready for stage 0, and v[s-1] for later stages.
  - When adv[s] is low, stage s holds data and valid unchanged.
- Latency: an input accepted at edge N appears on o/p/q with out_valid=1 after edge N+STAGES-1 when no stall occurs. Total latency is STAGES cycles.
- Throughput: one result per cycle when out_ready is held high.
- Outputs:
  - out_valid = v[STAGES-1]; o/p/q come from the last stage.
  - Data is stable whenever out_valid=1 and out_ready=0.
- Counter:
  - On each transfer (out_valid & out_ready), o_cnt += popcount(o).
  - Saturates at 2^CNT_W-1 and never wraps; o_cnt_sat = &o_cnt.
  - If cnt_clr and a transfer occur in the same cycle, the clear wins and o_cnt becomes 0.
- Reset (asynchronous, takes effect immediately on rst_n low, including mid-stream):
  - All v[] = 0, stage data = 0, o_cnt = 0.
  - Resulting outputs: out_valid=0, o=0, p=0, q=0, o_cnt_sat=0.
  - in_ready=1 during and after reset, because adv cascades from empty stages.
  - Data in flight is discarded.
- Boundary cases:
  - Full pipeline with out_ready=0: in_ready=0 and nothing is accepted; no data is lost or duplicated.
  - Pipeline with bubbles: empty stages always load (bubble collapse), so in_ready=1 even while out_ready=0.
  - in_valid=0 while in_ready=1: a bubble enters; operands are don't-care.
  - Logically q is all-ones for any operands (n is constant 0); the RTL still implements the full expression.

Decomposition:
- Package sample_pkg holds:
  - the lane-function localparams for MAX_WIDTH=64 and MAX_STAGES=4
  - a typedef struct res_t {o, p, q} sized by WIDTH, used through a parameterised type
  - popcount function popcnt(vec)
- Sub-module sample_lane_fn: purely combinational WIDTH-bit evaluation of the cone (a..f in, o/p/q out). It is instantiated once; the pipeline and counter stay in sample_pipe.

Test Plan:
1. Reset then single transfer. WIDTH=4, STAGES=2, out_ready=1. Inputs a=1111, b=1010, c=1100, d=0001, e=f=0000. Required: after 2 cycles out_valid=1, o=1000, p=0000, q=1111, o_cnt=1.
2. Second operand set. a=0000, d=0011, b=c=e=f=0000. Required: o=0000, p=1100, q=1111, o_cnt unchanged.
3. Backpressure. Stream 6 back-to-back inputs with out_ready=0 for cycles 2-5. Required: in_ready drops once both stages are full; all 6 results emerge in order with no loss or duplication; data is stable while stalled.
4. Bubble collapse. One input, then in_valid=0 for a cycle, then another input, with out_ready=0. Required: both results are held; in_ready is 0 only once both stages hold valid data.
5. Counter saturation and clear. CNT_W=4, repeated o=1111 transfers. Required: o_cnt steps 4, 8, 12, then holds at 15 with o_cnt_sat=1. cnt_clr asserted together with a transfer gives o_cnt=0.
6. Asynchronous reset mid-stream. Assert rst_n=0 between clock edges with the pipeline full. Required: out_valid=0 and o/p/q=0 immediately; o_cnt=0; in_ready=1; no stale output appears after release.

Source files
------------

// File: rtl/sample_pkg.sv
// Shared definitions for the sample_pipe slice.
//   MAX_WIDTH   - widest lane count any instance may use
//   MAX_STAGES  - deepest pipeline any instance may use
//   POPCNT_W    - width of a popcount over MAX_WIDTH lanes
//   res_max_t   - o/p/q result bundle at maximum width; instances declare
//                 their own WIDTH-sized copy of the same layout
//   popcnt()    - number of set bits in a MAX_WIDTH vector
package sample_pkg;

  localparam int MAX_WIDTH  = 64;
  localparam int MAX_STAGES = 4;
  localparam int POPCNT_W   = $clog2(MAX_WIDTH + 1);

  typedef struct packed {
    logic [MAX_WIDTH-1:0] o;
    logic [MAX_WIDTH-1:0] p;
    logic [MAX_WIDTH-1:0] q;
  } res_max_t;

  function automatic logic [POPCNT_W-1:0] popcnt(input logic [MAX_WIDTH-1:0] vec);
    logic [POPCNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      sum = sum + POPCNT_W'(vec[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/sample_lane_fn.sv
// Combinational evaluation of the sample logic cone over WIDTH lanes.
// Every lane is independent and identical.
// Ports:
//   a..f  in   WIDTH  operand lanes
//   o,p,q out  WIDTH  result lanes
module sample_lane_fn
  import sample_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] g, h, i, j, k, l, m, n;

  assign g = a | d;
  assign h = a & c;
  assign i = ~c;
  assign j = d | e | f;
  assign k = g | h | i;
  assign l = h & i & j;
  assign m = i & j;
  // n is logically zero (h needs c, i needs ~c) but the full cone is kept
  // so the netlist matches the original single-bit logic.
  assign n = l & m;

  assign o = b & h & k;
  assign p = ~g;
  assign q = ~n;

endmodule

// File: rtl/sample_pipe.sv
// Pipelined, WIDTH-lane version of the sample cone with a valid/ready
// handshake and a saturating counter of set o lanes on output transfers.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready combinational from out_ready)
//   a..f                  WIDTH-bit operands
//   out_valid / out_ready output handshake
//   o, p, q               WIDTH-bit results from the last stage
//   cnt_clr               synchronous clear of o_cnt (wins over a transfer)
//   o_cnt, o_cnt_sat      saturating count of set o bits, and its all-ones flag
module sample_pipe
  import sample_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] q,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_cnt_sat
);

  typedef struct packed {
    logic [WIDTH-1:0] o;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
  } res_t;

  localparam int SUM_W = CNT_W + POPCNT_W;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((64'd1 << CNT_W) - 64'd1);

  logic [WIDTH-1:0] lane_o, lane_p, lane_q;
  res_t             lane_res;
  res_t             stg [STAGES];
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;

  sample_lane_fn #(.WIDTH(WIDTH)) u_lane_fn (
    .a (a),
    .b (b),
    .c (c),
    .d (d),
    .e (e),
    .f (f),
    .o (lane_o),
    .p (lane_p),
    .q (lane_q)
  );

  assign lane_res = '{o: lane_o, p: lane_p, q: lane_q};

  // A stage advances when the consumer takes the output or when any stage
  // from it to the end is empty; written directly from v so the chain has
  // no combinational feedback through adv itself.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can
    // leave it unassigned and infer a latch.
    adv = '0;
    for (int s = 0; s < STAGES; s++) begin
      adv[s] = out_ready;
      for (int t = s; t < STAGES; t++) begin
        if (!v[t]) adv[s] = 1'b1;
      end
    end
  end

  assign in_ready = adv[0];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    // NOTE: stage data is reset along with the valid bits so outputs read
    // zero during and after reset, not stale in-flight values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // stage samples its predecessor's pre-edge value.
        v[s]   <= 1'b0;
        stg[s] <= '0;
      end else if (adv[s]) begin
        if (s == 0) begin
          v[s]   <= in_valid & in_ready;
          stg[s] <= lane_res;
        end else begin
          v[s]   <= v[s-1];
          stg[s] <= stg[s-1];
        end
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign o         = stg[STAGES-1].o;
  assign p         = stg[STAGES-1].p;
  assign q         = stg[STAGES-1].q;

  // Counter: sum is wide enough to hold o_cnt plus a full popcount, so the
  // comparison against CNT_MAX sees true overflow instead of a wrap.
  logic [SUM_W-1:0] cnt_sum;

  always_comb begin
    cnt_sum = SUM_W'(o_cnt) + SUM_W'(popcnt(MAX_WIDTH'(o)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cnt <= '0;
    end else if (cnt_clr) begin
      o_cnt <= '0;
    end else if (out_valid && out_ready) begin
      o_cnt <= (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
    end
  end

  assign o_cnt_sat = &o_cnt;

endmodule

// File: tb/tb_sample_pipe.sv
// Scoreboard bench for sample_pipe (WIDTH=4, STAGES=2). Stimulus pushes the
// expected o/p/q of each accepted input; a monitor pops and compares on each
// output transfer. A second instance with CNT_W=4 exercises saturation.
// Hand derivation of the cone used for expectations:
//   k contains h, so o = b&h = a&b&c;  p = ~(a|d);  q = all ones.
module tb_sample_pipe;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main instance
  logic         in_valid, in_ready, out_valid, out_ready, cnt_clr, o_cnt_sat;
  logic [W-1:0] a, b, c, d, e, f, o, p, q;
  logic [15:0]  o_cnt;

  sample_pipe #(.WIDTH(W), .STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
    .out_valid(out_valid), .out_ready(out_ready), .o(o), .p(p), .q(q),
    .cnt_clr(cnt_clr), .o_cnt(o_cnt), .o_cnt_sat(o_cnt_sat)
  );

  // saturation instance
  logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_cnt_clr, s_sat;
  logic [W-1:0] s_abc, s_zero, s_o, s_p, s_q;
  logic [3:0]   s_cnt;

  sample_pipe #(.WIDTH(W), .STAGES(2), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_abc), .b(s_abc), .c(s_abc), .d(s_zero), .e(s_zero), .f(s_zero),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .o(s_o), .p(s_p), .q(s_q),
    .cnt_clr(s_cnt_clr), .o_cnt(s_cnt), .o_cnt_sat(s_sat)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] o;
    logic [W-1:0] p;
    logic [W-1:0] q;
  } exp_t;

  exp_t sb [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] va, vb, vc, vd);
    exp_t r;
    r.o = va & vb & vc;
    r.p = ~(va | vd);
    r.q = '1;
    return r;
  endfunction

  // Drive one operand set; waits (bounded) for acceptance and pushes the
  // expected result when the DUT takes it. Entered and left at posedge+1.
  task automatic send(input logic [W-1:0] va, vb, vc, vd, ve, vf, input exp_t ex);
    logic ok;
    a = va; b = vb; c = vc; d = vd; e = ve; f = vf;
    in_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      if (ok) begin
        sb.push_back(ex);
        #1 in_valid = 1'b0;
        return;
      end
      #1;
    end
    check("send_accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare on every transfer; check stability while stalled.
  exp_t held;
  logic held_ok = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      held_ok = 1'b0;
    end else begin
      if (held_ok && out_valid)
        check("stall_stable", {o, p, q}, held);
      held_ok = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 64'd1, 64'd0);
        end else begin
          exp_t ex;
          ex = sb.pop_front();
          check("out_o", o, ex.o);
          check("out_p", p, ex.p);
          check("out_q", q, ex.q);
        end
      end else if (out_valid) begin
        held = '{o: o, p: p, q: q};
        held_ok = 1'b1;
      end
    end
  end

  // Saturation: one o=1111 input, then wait for its transfer (edge N+2).
  task automatic s_one(input logic [3:0] exp_cnt, input logic exp_sat);
    s_in_valid = 1'b1;
    @(posedge clk); #1 s_in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sat_cnt", s_cnt, exp_cnt);
    check("sat_flag", s_sat, exp_sat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    {a, b, c, d, e, f} = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_cnt_clr = 1'b0;
    s_abc = 4'b1111; s_zero = 4'b0000;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_o_cnt", o_cnt, 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single transfer
    send(4'b1111, 4'b1010, 4'b1100, 4'b0001, 4'b0000, 4'b0000,
         '{o: 4'b1000, p: 4'b0000, q: 4'b1111});
    @(posedge clk); #1;
    check("t1_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    check("t1_o_cnt", o_cnt, 16'd1);

    // 2: second operand set, o=0 so counter unchanged
    send(4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0000,
         '{o: 4'b0000, p: 4'b1100, q: 4'b1111});
    idle(2);
    check("t2_o_cnt", o_cnt, 16'd1);

    // 3: backpressure with six back-to-back inputs
    out_ready = 1'b0;
    send(4'b0111, 4'b0101, 4'b0011, 4'b1000, 4'b0001, 4'b0010, model(4'b0111, 4'b0101, 4'b0011, 4'b1000));
    send(4'b1110, 4'b1111, 4'b1011, 4'b0000, 4'b0000, 4'b0000, model(4'b1110, 4'b1111, 4'b1011, 4'b0000));
    @(negedge clk);
    check("t3_in_ready_full", in_ready, 1'b0);
    check("t3_out_valid_full", out_valid, 1'b1);
    @(posedge clk); #1;
    fork
      begin
        send(4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0000, 4'b0000, model(4'b0001, 4'b0001, 4'b0001, 4'b0100));
        send(4'b1001, 4'b1100, 4'b1111, 4'b0010, 4'b0000, 4'b0000, model(4'b1001, 4'b1100, 4'b1111, 4'b0010));
        send(4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, model(4'b0000, 4'b1111, 4'b1111, 4'b0000));
        send(4'b1111, 4'b0110, 4'b0111, 4'b1111, 4'b0000, 4'b0000, model(4'b1111, 4'b0110, 4'b0111, 4'b1111));
      end
      begin
        for (int t = 0; t < 3; t++) begin
          @(negedge clk);
          check("t3_stalled_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    idle(4);
    check("t3_drained", sb.size(), 0);

    // 4: bubble collapse with out_ready low
    out_ready = 1'b0;
    send(4'b1101, 4'b1111, 4'b0101, 4'b0000, 4'b0000, 4'b0000, model(4'b1101, 4'b1111, 4'b0101, 4'b0000));
    idle(1);
    @(negedge clk);
    check("t4_bubble_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    send(4'b0110, 4'b0010, 4'b0110, 4'b0001, 4'b0000, 4'b0000, model(4'b0110, 4'b0010, 4'b0110, 4'b0001));
    @(negedge clk);
    check("t4_full_in_ready", in_ready, 1'b0);
    check("t4_head_o", o, 4'b0101);
    @(posedge clk); #1 out_ready = 1'b1;
    idle(4);
    check("t4_drained", sb.size(), 0);

    // 5: saturation on the CNT_W=4 instance, then clear during a transfer
    s_one(4'd4, 1'b0);
    s_one(4'd8, 1'b0);
    s_one(4'd12, 1'b0);
    s_one(4'd15, 1'b1);
    s_one(4'd15, 1'b1);
    s_in_valid = 1'b1;
    @(posedge clk); #1 s_in_valid = 1'b0;
    @(posedge clk); #1 s_cnt_clr = 1'b1;
    check("t5_transfer_pending", s_out_valid, 1'b1);
    @(posedge clk); #1 s_cnt_clr = 1'b0;
    check("t5_clr_wins", s_cnt, 4'd0);
    check("t5_clr_sat", s_sat, 1'b0);

    // 6: asynchronous reset with the pipeline full
    out_ready = 1'b0;
    send(4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, model(4'b1111, 4'b1111, 4'b1111, 4'b0000));
    send(4'b1011, 4'b1011, 4'b1011, 4'b0000, 4'b0000, 4'b0000, model(4'b1011, 4'b1011, 4'b1011, 4'b0000));
    #2 rst_n = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_opq", {o, p, q}, 12'd0);
    check("t6_o_cnt", o_cnt, 16'd0);
    check("t6_in_ready", in_ready, 1'b1);
    sb.delete();
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    check("t6_no_stale", out_valid, 1'b0);
    check("t6_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
